load_unit: RTL



---
 rtl/load_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// RV32 data-memory load unit: one outstanding word-aligned read, then byte/half
// extraction with sign or zero extension for writeback.
module load_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_addr,
    input  logic [2:0]  i_ld_funct3,
    output logic        o_ld_ready,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_res_valid,
    output logic [31:0] o_res_data,
    output logic        o_res_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic [31:0] r_mem_addr;
    logic [31:0] r_res_data;
    logic        r_res_err;

    logic        w_accept;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_accept = (r_state == S_IDLE) && i_ld_valid;

    // Misaligned halfword/word and the unused funct3 codes never reach memory.
    always_comb begin
        w_err = 1'b1;
        case (i_ld_funct3)
            3'b000, 3'b100: w_err = 1'b0;
            3'b001, 3'b101: w_err = i_ld_addr[0];
            3'b010:         w_err = (i_ld_addr[1:0] != 2'b00);
            default:        w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_byte = i_mem_rdata[7:0];
        case (r_off)
            2'd0: w_byte = i_mem_rdata[7:0];
            2'd1: w_byte = i_mem_rdata[15:8];
            2'd2: w_byte = i_mem_rdata[23:16];
            2'd3: w_byte = i_mem_rdata[31:24];
            default: w_byte = i_mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        w_ext  = i_mem_rdata;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'b0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'b0, w_half};
            default: w_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_mem_req    = 1'b0;
        o_busy       = 1'b1;
        o_res_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_ld_valid) begin
                    w_next_state = w_err ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                o_res_valid  = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // res_err is only updated when a result is produced so it holds with res_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_off      <= 2'b00;
            r_funct3   <= 3'b000;
            r_mem_addr <= 32'h0;
            r_res_data <= 32'h0;
            r_res_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_off      <= i_ld_addr[1:0];
                r_funct3   <= i_ld_funct3;
                r_mem_addr <= {i_ld_addr[31:2], 2'b00};
                if (w_err) begin
                    r_res_data <= 32'h0;
                    r_res_err  <= 1'b1;
                end
            end
            if ((r_state == S_WAIT) && i_mem_rvalid) begin
                r_res_data <= w_ext;
                r_res_err  <= 1'b0;
            end
        end
    end

    assign o_ld_ready = !o_busy;
    assign o_mem_addr = r_mem_addr;
    assign o_res_data = r_res_data;
    assign o_res_err  = r_res_err;

endmodule
